// File: rtl/serial_magnitude_comparator.sv
// Nibble-serial magnitude comparator with a cascade input, MSB nibble first.
// Define CMP_EARLY_EXIT_EN to finish at the first decision; otherwise latency is a constant NIB edges.
module serial_magnitude_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cas_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  localparam logic [2:0] REL_GT = 3'b100;
  localparam logic [2:0] REL_LT = 3'b010;
  localparam logic [2:0] REL_EQ = 3'b001;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [2:0]       result_q, result_n;
  logic             done_q, done_n;
  logic [3:0]       nib_a, nib_b;
  logic [2:0]       nib_rel;
  logic             forcing;

`ifndef CMP_EARLY_EXIT_EN
  logic [2:0] dec_q, dec_n;
  logic       decided_q, decided_n;
`endif

  // Pick the nibble pair addressed by the current index.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  assign nib_rel = (nib_a > nib_b) ? REL_GT : ((nib_a < nib_b) ? REL_LT : REL_EQ);
  assign forcing = (cas_in == REL_GT) || (cas_in == REL_LT);

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    a_n      = a_q;
    b_n      = b_q;
    result_n = result_q;
    done_n   = 1'b0;
`ifndef CMP_EARLY_EXIT_EN
    dec_n     = dec_q;
    decided_n = decided_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_n   = a;
          b_n   = b;
          idx_n = LAST_IDX;
`ifdef CMP_EARLY_EXIT_EN
          if (forcing) begin
            result_n = cas_in;
            done_n   = 1'b1;
          end else begin
            state_n = SCAN;
          end
`else
          dec_n     = forcing ? cas_in : REL_EQ;
          decided_n = forcing;
          state_n   = SCAN;
`endif
        end
      end
      SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
        if (nib_rel != REL_EQ) begin
          result_n = nib_rel;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else if (idx_q == '0) begin
          result_n = REL_EQ;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else begin
          idx_n = idx_q - IDX_W'(1);
        end
`else
        // The first decision sticks; lower nibbles only matter while still equal.
        if (!decided_q && (nib_rel != REL_EQ)) begin
          dec_n     = nib_rel;
          decided_n = 1'b1;
        end
        if (idx_q == '0) begin
          result_n = dec_n;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else begin
          idx_n = idx_q - IDX_W'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= LAST_IDX;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= REL_EQ;
      done_q    <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      dec_q     <= REL_EQ;
      decided_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      a_q       <= a_n;
      b_q       <= b_n;
      result_q  <= result_n;
      done_q    <= done_n;
`ifndef CMP_EARLY_EXIT_EN
      dec_q     <= dec_n;
      decided_q <= decided_n;
`endif
    end
  end

  assign busy   = (state_q == SCAN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator; expected latencies follow CMP_EARLY_EXIT_EN.
module tb_serial_magnitude_comparator;

  localparam int WIDTH = 16;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       cas_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [2:0]       result;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [2:0] last_result  = 3'b001;
  int         hs_lat;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cas_in (cas_in),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [2:0] observed, input logic [2:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [2:0] c, input logic [WIDTH-1:0] av,
                                input logic [WIDTH-1:0] bv);
    start  = s;
    cas_in = c;
    a      = av;
    b      = bv;
  endtask

  // lat = edges after the accepting edge at which done appears (0 = at the accept edge).
  task automatic run_compare(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic [2:0] c, input logic [2:0] exp_res, input int lat);
    apply_stimulus(1'b1, c, av, bv);
    tick();
    apply_stimulus(1'b0, 3'b000, WIDTH'($urandom), WIDTH'($urandom));
    if (lat == 0) begin
      check_output({tag, "_done_accept"}, {2'b00, done}, 3'b001);
      check_output({tag, "_busy_accept"}, {2'b00, busy}, 3'b000);
      check_output({tag, "_result"}, result, exp_res);
    end else begin
      check_output({tag, "_busy_accept"}, {2'b00, busy}, 3'b001);
      check_output({tag, "_done_accept"}, {2'b00, done}, 3'b000);
      for (int k = 1; k <= lat; k++) begin
        tick();
        if (k < lat) begin
          check_output({tag, "_busy_mid"}, {2'b00, busy}, 3'b001);
          check_output({tag, "_done_mid"}, {2'b00, done}, 3'b000);
          check_output({tag, "_result_hold"}, result, last_result);
        end else begin
          check_output({tag, "_done"}, {2'b00, done}, 3'b001);
          check_output({tag, "_busy_end"}, {2'b00, busy}, 3'b000);
          check_output({tag, "_result"}, result, exp_res);
        end
      end
    end
    last_result = exp_res;
    tick();
    check_output({tag, "_done_pulse"}, {2'b00, done}, 3'b000);
    check_output({tag, "_result_kept"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b1, 3'b000, 16'h1234, 16'h0001);

    // Reset wins over start for two cycles.
    for (int k = 0; k < 2; k++) begin
      tick();
      check_output("reset_busy", {2'b00, busy}, 3'b000);
      check_output("reset_done", {2'b00, done}, 3'b000);
      check_output("reset_result", result, 3'b001);
    end
    rst = 1'b0;
    apply_stimulus(1'b0, 3'b000, 16'h0000, 16'h0000);
    tick();
    check_output("post_reset_done", {2'b00, done}, 3'b000);
    check_output("post_reset_busy", {2'b00, busy}, 3'b000);

    run_compare("equal", 16'hA5C3, 16'hA5C3, 3'b000, 3'b001, 4);
    run_compare("msb_gt", 16'h8000, 16'h7FFF, 3'b000, 3'b100, EARLY ? 1 : 4);
    run_compare("lsb_lt", 16'h1230, 16'h1231, 3'b000, 3'b010, 4);
    run_compare("force_gt", 16'h0000, 16'hFFFF, 3'b100, 3'b100, EARLY ? 0 : 4);
    run_compare("force_lt", 16'hFFFF, 16'h0000, 3'b010, 3'b010, EARLY ? 0 : 4);
    run_compare("cas111_eq", 16'h5A5A, 16'h5A5A, 3'b111, 3'b001, 4);
    run_compare("mid_lt", 16'h3400, 16'h3500, 3'b011, 3'b010, EARLY ? 2 : 4);

    // Start held high: mid-busy starts ignored, back-to-back accept in the done cycle.
    hs_lat = EARLY ? 3 : 4;
    apply_stimulus(1'b1, 3'b000, 16'h0010, 16'h0001);
    tick();
    check_output("hs_busy_accept", {2'b00, busy}, 3'b001);
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= hs_lat; k++) begin
        tick();
        if (k < hs_lat) begin
          check_output("hs_busy_mid", {2'b00, busy}, 3'b001);
          check_output("hs_done_mid", {2'b00, done}, 3'b000);
        end else begin
          check_output("hs_done", {2'b00, done}, 3'b001);
          check_output("hs_result", result, 3'b100);
        end
      end
      tick();
      check_output("hs_reaccept_busy", {2'b00, busy}, 3'b001);
      check_output("hs_reaccept_done", {2'b00, done}, 3'b000);
      check_output("hs_result_hold", result, 3'b100);
    end

    // Reset in the middle of a scan discards the compare.
    tick();
    check_output("hs_scan_busy", {2'b00, busy}, 3'b001);
    rst   = 1'b1;
    start = 1'b0;
    tick();
    check_output("midscan_rst_busy", {2'b00, busy}, 3'b000);
    check_output("midscan_rst_done", {2'b00, done}, 3'b000);
    check_output("midscan_rst_result", result, 3'b001);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output("after_rst_no_done", {2'b00, done}, 3'b000);
      check_output("after_rst_idle", {2'b00, busy}, 3'b000);
    end
    check_output("after_rst_result", result, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
